// File: rtl/fb_scanout_reader.sv
// Frame buffer scanout: streams one 256x240 frame from the packed 72-bit URAM store
// as a valid/ready pixel stream, prefetching words through a credit-limited FIFO.
module fb_scanout_reader #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  ram_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [71:0]           ram_do,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [5:0]            pix_color,
    output logic [7:0]            pix_x,
    output logic [7:0]            pix_y,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned FrameWords = 7680;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CreditW    = CntW + 2;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  ram_rd_q, ram_rd_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    logic [71:0]           fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;

    logic [71:0]           word_q, word_d;
    logic [2:0]            lane_q, lane_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [5:0]            color_q, color_d;
    logic [7:0]            x_q, x_d;
    logic [7:0]            y_q, y_d;
    logic                  done_q, done_d;

    logic [CreditW-1:0]    credit_used;
    logic                  issue;
    logic                  last_issue;
    logic                  push;
    logic                  pop;
    logic                  hs;
    logic                  last_lane;
    logic                  frame_last;
    logic [2:0]            lane_inc;
    logic [71:0]           fifo_head;

    // Words already promised to the FIFO: stored, returning, or just issued.
    always_comb begin
        credit_used = CreditW'(fifo_cnt_q) + CreditW'(ram_rd_q);
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            credit_used = credit_used + CreditW'(rd_pipe_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start && !done_q) state_d = StFetch;
            StFetch: if (last_issue) state_d = StDrain;
            StDrain: if (frame_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue = (state_q == StFetch) && (credit_used < CreditW'(FIFO_DEPTH));
        busy  = (state_q != StIdle);
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        ram_rd_d   = issue;
        ram_addr_d = ram_addr_q;
        if (state_q == StIdle) begin
            rd_cnt_d = '0;
        end else if (issue) begin
            ram_addr_d = rd_cnt_q;
            rd_cnt_d   = rd_cnt_q + 1'b1;
        end
        last_issue = issue && (rd_cnt_q == ADDR_WIDTH'(FrameWords - 1));

        rd_pipe_d[0] = ram_rd_q;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        push = rd_pipe_q[RD_LATENCY-1];
    end

    always_comb begin
        hs         = pix_valid_q && pix_ready;
        last_lane  = (lane_q == 3'd7);
        frame_last = hs && (x_q == 8'd255) && (y_q == 8'd239);
        fifo_head  = fifo_mem_q[rd_ptr_q];
        pop        = (fifo_cnt_q != '0) && (!pix_valid_q || (hs && last_lane));
        lane_inc   = lane_q + 3'd1;

        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        word_d      = word_q;
        lane_d      = lane_q;
        pix_valid_d = pix_valid_q;
        color_d     = color_q;
        if (hs && !last_lane) begin
            lane_d  = lane_inc;
            color_d = word_q[{lane_inc, 3'b000} +: 6];
        end
        if (pop) begin
            word_d      = fifo_head;
            lane_d      = 3'd0;
            color_d     = fifo_head[5:0];
            pix_valid_d = 1'b1;
        end else if (hs && last_lane) begin
            pix_valid_d = 1'b0;
        end

        x_d = x_q;
        y_d = y_q;
        if (hs) begin
            x_d = x_q + 8'd1;
            if (x_q == 8'd255) begin
                y_d = (y_q == 8'd239) ? 8'd0 : y_q + 8'd1;
            end
        end
        done_d = frame_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q    <= '0;
            ram_rd_q    <= 1'b0;
            ram_addr_q  <= '0;
            rd_pipe_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            pix_valid_q <= 1'b0;
            color_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            done_q      <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            ram_rd_q    <= ram_rd_d;
            ram_addr_q  <= ram_addr_d;
            rd_pipe_q   <= rd_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            pix_valid_q <= pix_valid_d;
            color_q     <= color_d;
            x_q         <= x_d;
            y_q         <= y_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset; emptiness is carried by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= ram_do;
        end
    end

    assign ram_rd    = ram_rd_q;
    assign ram_addr  = ram_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_color = color_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_sof   = pix_valid_q && (x_q == 8'd0) && (y_q == 8'd0);
    assign pix_eol   = pix_valid_q && (x_q == 8'd255);
    assign done      = done_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: three instances (two default, one with RD_LATENCY=3 and
// FIFO_DEPTH=2) run concurrently against a raster-order pixel reference.
module tb_fb_scanout_reader;
    localparam int NI        = 3;
    localparam int FRAME_PIX = 61440;
    localparam int FRAME_WRD = 7680;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset       [NI];
    logic        frame_start [NI];
    logic        ram_rd      [NI];
    logic [12:0] ram_addr    [NI];
    logic [71:0] ram_do      [NI];
    logic        pix_valid   [NI];
    logic        pix_ready   [NI];
    logic [5:0]  pix_color   [NI];
    logic [7:0]  pix_x       [NI];
    logic [7:0]  pix_y       [NI];
    logic        pix_sof     [NI];
    logic        pix_eol     [NI];
    logic        busy        [NI];
    logic        done        [NI];

    int n_tests;
    int n_fail;

    function automatic int lat_of(input int u);
        return (u == 2) ? 3 : 1;
    endfunction

    function automatic int dep_of(input int u);
        return (u == 2) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fb_scanout_reader #(
            .ADDR_WIDTH(13),
            .RD_LATENCY((g == 2) ? 3 : 1),
            .FIFO_DEPTH((g == 2) ? 2 : 4)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .frame_start(frame_start[g]),
            .ram_rd     (ram_rd[g]),
            .ram_addr   (ram_addr[g]),
            .ram_do     (ram_do[g]),
            .pix_valid  (pix_valid[g]),
            .pix_ready  (pix_ready[g]),
            .pix_color  (pix_color[g]),
            .pix_x      (pix_x[g]),
            .pix_y      (pix_y[g]),
            .pix_sof    (pix_sof[g]),
            .pix_eol    (pix_eol[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

    // Word n lane i holds (8n+i)&63; spare lane bits and lane 8 carry junk.
    function automatic logic [71:0] mk_word(input logic [12:0] n);
        logic [71:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = {2'(int'(n) + i + 1), 6'((int'(n) * 8 + i) & 63)};
        end
        w[71:64] = n[7:0] ^ 8'hA5;
        return w;
    endfunction

    logic [12:0] ap [NI][4];
    always @(posedge clk) begin
        for (int u = 0; u < NI; u++) begin
            ap[u][0] <= ram_addr[u];
            for (int s = 1; s < 4; s++) ap[u][s] <= ap[u][s-1];
        end
    end
    always_comb begin
        for (int u = 0; u < NI; u++) ram_do[u] = mk_word(ap[u][lat_of(u)-1]);
    end

    task automatic test_reset();
        for (int u = 0; u < NI; u++) begin
            reset[u] = 1'b1;
            frame_start[u] = 1'b0;
            pix_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NI; u++) begin
            n_tests++;
            if (ram_rd[u] !== 1'b0 || ram_addr[u] !== 13'd0 || pix_valid[u] !== 1'b0 ||
                pix_color[u] !== 6'd0 || pix_x[u] !== 8'd0 || pix_y[u] !== 8'd0 ||
                pix_sof[u] !== 1'b0 || pix_eol[u] !== 1'b0 || busy[u] !== 1'b0 ||
                done[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL u%0d reset_state: rd=%b addr=%0d v=%b busy=%b done=%b want all 0",
                         u, ram_rd[u], ram_addr[u], pix_valid[u], busy[u], done[u]);
            end
            reset[u] = 1'b0;
        end
    endtask

    task automatic test_abort_reset(input int u);
        int pix = 0;
        int k = 0;
        @(negedge clk);
        frame_start[u] = 1'b1;
        pix_ready[u] = 1'b1;
        while (pix <= 1000 && k < 5000) begin
            @(negedge clk);
            k++;
            frame_start[u] = 1'b0;
            if (pix_valid[u] === 1'b1) begin
                n_tests++;
                if (pix_color[u] !== 6'(pix & 63)) begin
                    n_fail++;
                    $display("FAIL u%0d abort_pre_color px%0d: got %0d want %0d",
                             u, pix, pix_color[u], pix & 63);
                end
                pix++;
            end
        end
        n_tests++;
        if (pix <= 1000) begin
            n_fail++;
            $display("FAIL u%0d abort_reach_1000: got %0d pixels want >1000", u, pix);
        end
        reset[u] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ram_rd[u] !== 1'b0 || ram_addr[u] !== 13'd0 || pix_valid[u] !== 1'b0 ||
            pix_color[u] !== 6'd0 || pix_x[u] !== 8'd0 || pix_y[u] !== 8'd0 ||
            pix_sof[u] !== 1'b0 || pix_eol[u] !== 1'b0 || busy[u] !== 1'b0 ||
            done[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL u%0d abort_outputs: rd=%b addr=%0d v=%b x=%0d y=%0d busy=%b want 0",
                     u, ram_rd[u], ram_addr[u], pix_valid[u], pix_x[u], pix_y[u], busy[u]);
        end
        reset[u] = 1'b0;
    endtask

    // Streams one frame and checks every pixel, read address, credit and handshake rule.
    task automatic test_stream(input int u, input int low_pct, input int rand_pix,
                               input bit poke, input bit chk_bubbles);
        int k = -1;
        int pix = 0;
        int issued = 0;
        int bad = 0;
        int first_k = -1;
        int bubbles = 0;
        int done_cnt = 0;
        int last_acc_k = -10;
        int occ;
        bit done_seen = 1'b0;
        bit stalled = 1'b0;
        bit poked = 1'b0;
        logic [5:0] pc;
        logic [7:0] px, py;
        logic ps, pe;
        @(negedge clk);
        frame_start[u] = 1'b1;
        pix_ready[u] = 1'b1;
        while (!done_seen && k < 100000 && bad < 20) begin
            @(negedge clk);
            k++;
            frame_start[u] = 1'b0;
            if (ram_rd[u] === 1'b1) begin
                n_tests++;
                if (ram_addr[u] !== 13'(issued)) begin
                    n_fail++; bad++;
                    $display("FAIL u%0d rd_addr: got %0d want %0d", u, ram_addr[u], issued);
                end
                issued++;
            end
            occ = issued - pix / 8 - ((pix_valid[u] === 1'b1) ? 1 : 0);
            n_tests++;
            if (occ > dep_of(u) || occ < 0) begin
                n_fail++; bad++;
                $display("FAIL u%0d credit: outstanding %0d want <= %0d", u, occ, dep_of(u));
            end
            if (done[u] === 1'b1) begin
                done_seen = 1'b1;
                done_cnt++;
                n_tests++;
                if (pix != FRAME_PIX || last_acc_k != k - 1 || busy[u] !== 1'b0) begin
                    n_fail++; bad++;
                    $display("FAIL u%0d done_timing: pix=%0d lastk=%0d k=%0d busy=%b want %0d,k-1,0",
                             u, pix, last_acc_k, k, busy[u], FRAME_PIX);
                end
            end else begin
                n_tests++;
                if (busy[u] !== 1'b1) begin
                    n_fail++; bad++;
                    $display("FAIL u%0d busy: got %b want 1 at cycle %0d", u, busy[u], k);
                end
            end
            if (pix_valid[u] === 1'b1) begin
                if (first_k < 0) first_k = k;
                n_tests++;
                if (pix >= FRAME_PIX) begin
                    n_fail++; bad++;
                    $display("FAIL u%0d extra_pixel: got valid after %0d pixels", u, pix);
                end else if (pix_color[u] !== 6'(pix & 63) || pix_x[u] !== 8'(pix % 256) ||
                             pix_y[u] !== 8'(pix / 256) || pix_sof[u] !== (pix == 0) ||
                             pix_eol[u] !== ((pix % 256) == 255)) begin
                    n_fail++; bad++;
                    $display("FAIL u%0d pixel %0d: got c=%0d x=%0d y=%0d s=%b e=%b want c=%0d x=%0d y=%0d",
                             u, pix, pix_color[u], pix_x[u], pix_y[u], pix_sof[u], pix_eol[u],
                             pix & 63, pix % 256, pix / 256);
                end
                if (stalled) begin
                    n_tests++;
                    if (pix_color[u] !== pc || pix_x[u] !== px || pix_y[u] !== py ||
                        pix_sof[u] !== ps || pix_eol[u] !== pe) begin
                        n_fail++; bad++;
                        $display("FAIL u%0d stall_hold: got c=%0d x=%0d want c=%0d x=%0d",
                                 u, pix_color[u], pix_x[u], pc, px);
                    end
                end
            end else if (stalled) begin
                n_tests++;
                n_fail++; bad++;
                $display("FAIL u%0d stall_valid: got valid=%b want 1", u, pix_valid[u]);
            end else if (chk_bubbles && first_k >= 0 && pix < FRAME_PIX) begin
                bubbles++;
            end
            if (pix < rand_pix) pix_ready[u] = (int'($urandom_range(0, 99)) >= low_pct);
            else pix_ready[u] = 1'b1;
            stalled = (pix_valid[u] === 1'b1) && !pix_ready[u];
            pc = pix_color[u]; px = pix_x[u]; py = pix_y[u];
            ps = pix_sof[u]; pe = pix_eol[u];
            if (pix_valid[u] === 1'b1 && pix_ready[u]) begin
                pix++;
                last_acc_k = k;
            end
            if (poke && !poked && pix == 500) begin
                frame_start[u] = 1'b1;
                poked = 1'b1;
            end
            if (poke && done_seen) frame_start[u] = 1'b1;
        end
        n_tests++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL u%0d frame_end: no done after %0d cycles, %0d pixels", u, k, pix);
        end
        n_tests++;
        if (pix != FRAME_PIX) begin
            n_fail++;
            $display("FAIL u%0d pixel_count: got %0d want %0d", u, pix, FRAME_PIX);
        end
        n_tests++;
        if (issued != FRAME_WRD) begin
            n_fail++;
            $display("FAIL u%0d read_count: got %0d want %0d", u, issued, FRAME_WRD);
        end
        n_tests++;
        if (first_k < 0 || first_k > lat_of(u) + 3) begin
            n_fail++;
            $display("FAIL u%0d first_valid: got cycle %0d want <= %0d", u, first_k, lat_of(u) + 3);
        end
        if (chk_bubbles) begin
            n_tests++;
            if (bubbles != 0) begin
                n_fail++;
                $display("FAIL u%0d bubbles: got %0d want 0", u, bubbles);
            end
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            frame_start[u] = 1'b0;
            if (done[u] === 1'b1) done_cnt++;
            n_tests++;
            if (busy[u] !== 1'b0 || pix_valid[u] !== 1'b0 || ram_rd[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL u%0d idle_after: busy=%b valid=%b rd=%b want 0 0 0",
                         u, busy[u], pix_valid[u], ram_rd[u]);
            end
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL u%0d done_count: got %0d want 1", u, done_cnt);
        end
    endtask

    task automatic test_full_frame();
        test_stream(0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_random_ready();
        test_abort_reset(1);
        test_stream(1, 30, 20480, 1'b0, 1'b0);
    endtask

    task automatic test_small_fifo();
        test_stream(2, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        fork
            test_full_frame();
            test_random_ready();
            test_small_fifo();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
